// File: rtl/rf_port_arbiter.sv
// Two-client arbiter for a single-read-pair/single-write register file.
// Round-robin on ties, optional lock for back-to-back ownership.
module rf_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_req,
  input  logic              c0_lock,
  input  logic [ADDR_W-1:0] c0_ra,
  input  logic [ADDR_W-1:0] c0_rb,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_rw,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_gnt,
  output logic              c0_rvalid,
  output logic [DATA_W-1:0] c0_rdata_a,
  output logic [DATA_W-1:0] c0_rdata_b,
  input  logic              c1_req,
  input  logic              c1_lock,
  input  logic [ADDR_W-1:0] c1_ra,
  input  logic [ADDR_W-1:0] c1_rb,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_rw,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_gnt,
  output logic              c1_rvalid,
  output logic [DATA_W-1:0] c1_rdata_a,
  output logic [DATA_W-1:0] c1_rdata_b,
  output logic              rf_rst,
  output logic [ADDR_W-1:0] rf_ra,
  output logic [ADDR_W-1:0] rf_rb,
  output logic [ADDR_W-1:0] rf_rw,
  output logic              rf_wren,
  output logic [DATA_W-1:0] rf_busw,
  input  logic [DATA_W-1:0] rf_busa,
  input  logic [DATA_W-1:0] rf_busb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_t;

  own_t              r_state;
  own_t              w_state_nxt;
  logic              r_prio;
  logic              w_prio_nxt;
  logic              w_g0;
  logic              w_g1;
  logic              r_rv0;
  logic              r_rv1;
  logic [ADDR_W-1:0] r_ra;
  logic [ADDR_W-1:0] r_rb;
  logic [ADDR_W-1:0] r_rw;
  logic [DATA_W-1:0] r_busw;

  // Grant selection and ownership/priority next-state.
  always_comb begin
    w_g0        = 1'b0;
    w_g1        = 1'b0;
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          if (c0_req && (!c1_req || !r_prio))
            w_g0 = 1'b1;
          else if (c1_req)
            w_g1 = 1'b1;
          if (w_g0) begin
            w_prio_nxt = 1'b1;
            if (c0_lock)
              w_state_nxt = OWN0;
          end else if (w_g1) begin
            w_prio_nxt = 1'b0;
            if (c1_lock)
              w_state_nxt = OWN1;
          end
        end
        OWN0: begin
          w_g0 = c0_req;
          if (!(c0_req && c0_lock)) begin
            w_state_nxt = IDLE;
            w_prio_nxt  = 1'b1;
          end
        end
        OWN1: begin
          w_g1 = c1_req;
          if (!(c1_req && c1_lock)) begin
            w_state_nxt = IDLE;
            w_prio_nxt  = 1'b0;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Ownership, priority and read-valid pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
      r_rv0   <= 1'b0;
      r_rv1   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
      r_rv0   <= w_g0;
      r_rv1   <= w_g1;
    end
  end

  // Remember the last issued addresses so idle cycles hold them.
  always_ff @(posedge clk) begin
    if (w_g0) begin
      r_ra   <= c0_ra;
      r_rb   <= c0_rb;
      r_rw   <= c0_rw;
      r_busw <= c0_wdata;
    end else if (w_g1) begin
      r_ra   <= c1_ra;
      r_rb   <= c1_rb;
      r_rw   <= c1_rw;
      r_busw <= c1_wdata;
    end
  end

  // Register-file port mux.
  always_comb begin
    rf_ra   = r_ra;
    rf_rb   = r_rb;
    rf_rw   = r_rw;
    rf_busw = r_busw;
    rf_wren = 1'b0;
    if (w_g0) begin
      rf_ra   = c0_ra;
      rf_rb   = c0_rb;
      rf_rw   = c0_rw;
      rf_busw = c0_wdata;
      rf_wren = c0_we;
    end else if (w_g1) begin
      rf_ra   = c1_ra;
      rf_rb   = c1_rb;
      rf_rw   = c1_rw;
      rf_busw = c1_wdata;
      rf_wren = c1_we;
    end
  end

  assign rf_rst     = rst;
  assign c0_gnt     = w_g0;
  assign c1_gnt     = w_g1;
  assign c0_rvalid  = r_rv0;
  assign c1_rvalid  = r_rv1;
  assign c0_rdata_a = rf_busa;
  assign c0_rdata_b = rf_busb;
  assign c1_rdata_a = rf_busa;
  assign c1_rdata_b = rf_busb;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Scoreboard bench for rf_port_arbiter with a behavioural
// write-first register file attached.
module tb_rf_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          c0_req, c0_lock, c0_we;
  logic [AW-1:0] c0_ra, c0_rb, c0_rw;
  logic [DW-1:0] c0_wdata;
  logic          c0_gnt, c0_rvalid;
  logic [DW-1:0] c0_rdata_a, c0_rdata_b;
  logic          c1_req, c1_lock, c1_we;
  logic [AW-1:0] c1_ra, c1_rb, c1_rw;
  logic [DW-1:0] c1_wdata;
  logic          c1_gnt, c1_rvalid;
  logic [DW-1:0] c1_rdata_a, c1_rdata_b;
  logic          rf_rst, rf_wren;
  logic [AW-1:0] rf_ra, rf_rb, rf_rw;
  logic [DW-1:0] rf_busw, rf_busa, rf_busb;

  always #5 clk = ~clk;

  rf_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c0_lock(c0_lock),
    .c0_ra(c0_ra), .c0_rb(c0_rb),
    .c0_we(c0_we), .c0_rw(c0_rw),
    .c0_wdata(c0_wdata), .c0_gnt(c0_gnt),
    .c0_rvalid(c0_rvalid),
    .c0_rdata_a(c0_rdata_a),
    .c0_rdata_b(c0_rdata_b),
    .c1_req(c1_req), .c1_lock(c1_lock),
    .c1_ra(c1_ra), .c1_rb(c1_rb),
    .c1_we(c1_we), .c1_rw(c1_rw),
    .c1_wdata(c1_wdata), .c1_gnt(c1_gnt),
    .c1_rvalid(c1_rvalid),
    .c1_rdata_a(c1_rdata_a),
    .c1_rdata_b(c1_rdata_b),
    .rf_rst(rf_rst), .rf_ra(rf_ra),
    .rf_rb(rf_rb), .rf_rw(rf_rw),
    .rf_wren(rf_wren), .rf_busw(rf_busw),
    .rf_busa(rf_busa), .rf_busb(rf_busb)
  );

  // Register file: sampled on the edge, write-first read ports.
  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    if (rf_rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      rf_busa <= '0;
      rf_busb <= '0;
    end else begin
      if (rf_wren) mem[rf_rw] <= rf_busw;
      rf_busa <= (rf_wren && rf_rw == rf_ra) ? rf_busw : mem[rf_ra];
      rf_busb <= (rf_wren && rf_rw == rf_rb) ? rf_busw : mem[rf_rb];
    end
  end

  typedef struct {
    bit          g0;
    bit          g1;
    bit          we;
    bit          rv0;
    bit          rv1;
    bit          chk;
    logic [15:0] d;
  } exp_t;

  exp_t        q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  bit          p_g0   = 0;
  bit          p_g1   = 0;
  bit          p_chk  = 0;
  logic [15:0] p_d    = '0;

  function automatic void ck(string nm, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // One cycle of stimulus: this cycle's grant/wren, and the
  // data expected back next cycle from this grant.
  task automatic step(input bit g0, input bit g1, input bit we,
                      input bit chk, input logic [15:0] d);
    exp_t e;
    e.g0  = g0;
    e.g1  = g1;
    e.we  = we;
    e.rv0 = p_g0;
    e.rv1 = p_g1;
    e.chk = p_chk;
    e.d   = p_d;
    q.push_back(e);
    p_g0  = g0;
    p_g1  = g1;
    p_chk = chk;
    p_d   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    c0_req = 0; c0_lock = 0; c0_we = 0;
    c0_ra = '0; c0_rb = '0; c0_rw = '0; c0_wdata = '0;
    c1_req = 0; c1_lock = 0; c1_we = 0;
    c1_ra = '0; c1_rb = '0; c1_rw = '0; c1_wdata = '0;
  endtask

  // Monitor: compare every presented cycle against the scoreboard.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      ck("c0_gnt", 16'(c0_gnt), 16'(e.g0));
      ck("c1_gnt", 16'(c1_gnt), 16'(e.g1));
      ck("rf_wren", 16'(rf_wren), 16'(e.we));
      ck("c0_rvalid", 16'(c0_rvalid), 16'(e.rv0));
      ck("c1_rvalid", 16'(c1_rvalid), 16'(e.rv1));
      if (e.chk && e.rv0) ck("c0_rdata_a", c0_rdata_a, e.d);
      if (e.chk && e.rv1) ck("c1_rdata_a", c1_rdata_a, e.d);
    end
  end

  initial begin
    clr();
    rst = 1;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 16'h0);
    rst = 0;
    // write r3 then read it back
    c0_req = 1; c0_we = 1; c0_rw = 3; c0_wdata = 16'hBEEF;
    step(1, 0, 1, 0, 16'h0);
    c0_we = 0; c0_ra = 3;
    step(1, 0, 0, 1, 16'hBEEF);
    // write-first on same address
    c0_we = 1; c0_rw = 5; c0_wdata = 16'h1234; c0_ra = 5;
    step(1, 0, 1, 1, 16'h1234);
    clr();
    step(0, 0, 0, 0, 16'h0);
    // reset with both requesting: no grant, no write
    rst = 1;
    c0_req = 1; c1_req = 1; c0_we = 1; c1_we = 1;
    step(0, 0, 0, 0, 16'h0);
    rst = 0;
    // alternating tie
    c0_rw = 7; c0_ra = 7; c0_wdata = 16'hAAAA;
    c1_rw = 8; c1_ra = 8; c1_wdata = 16'h5555;
    step(1, 0, 1, 1, 16'hAAAA);
    step(0, 1, 1, 1, 16'h5555);
    step(1, 0, 1, 1, 16'hAAAA);
    step(0, 1, 1, 1, 16'h5555);
    clr();
    step(0, 0, 0, 0, 16'h0);
    // c0 alone hands the tie to c1
    c0_req = 1; c0_ra = 7;
    step(1, 0, 0, 1, 16'hAAAA);
    // c1 locks three accesses
    c0_ra = 8; c1_req = 1; c1_lock = 1; c1_ra = 8;
    step(0, 1, 0, 1, 16'h5555);
    step(0, 1, 0, 1, 16'h5555);
    c1_lock = 0; c1_we = 1; c1_rw = 8; c1_wdata = 16'h5556;
    step(0, 1, 1, 1, 16'h5556);
    clr();
    c0_req = 1; c0_ra = 8;
    step(1, 0, 0, 1, 16'h5556);
    // c0 takes ownership, reset lands mid-lock
    c0_lock = 1;
    step(1, 0, 0, 1, 16'h5556);
    c1_req = 1; c0_we = 1; c0_rw = 3; c0_wdata = 16'h1111; c0_ra = 3;
    step(1, 0, 1, 1, 16'h1111);
    rst = 1;
    step(0, 0, 0, 0, 16'h0);
    rst = 0;
    c0_lock = 0; c0_we = 0;
    c1_ra = 8; c1_we = 1; c1_rw = 9; c1_wdata = 16'h2222;
    step(1, 0, 0, 1, 16'h0000);
    step(0, 1, 1, 1, 16'h0000);
    // idle with we held high must not write
    clr();
    c0_we = 1; c0_rw = 9; c0_wdata = 16'hFFFF; c0_ra = 9;
    c1_we = 1; c1_rw = 9; c1_wdata = 16'hEEEE;
    step(0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);
    clr();
    c0_req = 1; c0_ra = 9;
    step(1, 0, 0, 1, 16'h2222);
    clr();
    step(0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
